// File: rtl/acu_bank.sv
// Bank of NREG address registers with byte-lane loads, inc/dec/offset modify,
// a one-cycle wrap pulse and a tri-stated read port for the selected register.

module acu_reg #(
  parameter int DW = 8,
  parameter int AW = 16,
  parameter int LW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hit,
  input  logic          we,
  input  logic          en,
  input  logic [1:0]    op,
  input  logic [LW-1:0] lane,
  input  logic [DW-1:0] d,
  output logic [AW-1:0] r,
  output logic          wrp
);
  localparam int NL = AW / DW;

  logic [AW-1:0] b;
  logic [AW:0]   sum;
  logic          neg, mod;

  // Every op is an add of b; for a negative addend the unsigned result left
  // range exactly when the adder did NOT carry out, hence carry ^ neg.
  always_comb begin
    b   = '0;
    neg = 1'b0;
    case (op)
      2'b01: b = AW'(1);
      2'b10: begin b = '1; neg = 1'b1; end
      2'b11: begin b = AW'($signed(d)); neg = b[AW-1]; end
      default: ;
    endcase
    sum = {1'b0, r} + {1'b0, b};
  end

  assign mod = hit & ~we & en & (op != 2'b00);
  assign wrp = mod & (sum[AW] ^ neg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '0;
    end else if (hit && we) begin
      for (int k = 0; k < NL; k++)
        if (lane == LW'(k)) r[k*DW +: DW] <= d;
    end else if (mod) begin
      r <= sum[AW-1:0];
    end
  end
endmodule

module acu_bank #(
  parameter int DW   = 8,
  parameter int AW   = 16,
  parameter int NREG = 4,
  localparam int SW  = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int LW  = ((AW / DW) > 1) ? $clog2(AW / DW) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  input  logic [SW-1:0] sel,
  input  logic [LW-1:0] lane,
  input  logic          we,
  input  logic          en,
  input  logic [1:0]    op,
  input  logic          oe,
  output logic [AW-1:0] q,
  output logic          wrap
);
  if ((AW % DW) != 0 || AW < DW) begin : g_bad_params
    $error("acu_bank: AW must be a positive integer multiple of DW");
  end

  logic [NREG-1:0]         hit, wv;
  logic [NREG-1:0][AW-1:0] regs;
  logic [AW-1:0]           qv;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    assign hit[i] = (sel == SW'(i));
    acu_reg #(.DW(DW), .AW(AW), .LW(LW)) u_reg (
      .clk (clk),
      .rst (rst),
      .hit (hit[i]),
      .we  (we),
      .en  (en),
      .op  (op),
      .lane(lane),
      .d   (d),
      .r   (regs[i]),
      .wrp (wv[i])
    );
  end

  // An out-of-range sel matches no register, so it reads back as zero.
  always_comb begin
    qv = '0;
    for (int i = 0; i < NREG; i++)
      if (hit[i]) qv = regs[i];
  end

  assign q = oe ? qv : {AW{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wrap <= 1'b0;
    else      wrap <= |wv;
  end
endmodule

// File: tb/tb_acu_bank.sv
// Directed-vector scoreboard bench for acu_bank at default parameters.

module tb_acu_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  d;
  logic [1:0]  sel;
  logic        lane;
  logic        we, en, oe;
  logic [1:0]  op;
  logic [15:0] q;
  logic        wrap;

  acu_bank dut (
    .clk(clk), .rst(rst), .d(d), .sel(sel), .lane(lane), .we(we),
    .en(en), .op(op), .oe(oe), .q(q), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] q;
    logic        w;
    bit          neq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: the DUT output is sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.neq) begin
        if (q === e.q) begin
          errors++;
          $display("FAIL %s: q=%h still driving stored value %h", e.nm, q, e.q);
        end
      end else if (q !== e.q || wrap !== e.w) begin
        errors++;
        $display("FAIL %s: got q=%h wrap=%b, expected q=%h wrap=%b",
                 e.nm, q, wrap, e.q, e.w);
      end
    end
  end

  task automatic cyc(input logic [1:0] s, input logic l, input logic [7:0] dd,
                     input logic w, input logic e, input logic [1:0] o);
    sel = s; lane = l; d = dd; we = w; en = e; op = o;
    @(posedge clk); #1;
    we = 1'b0; en = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [15:0] eq, input logic ew,
                     input bit neq = 1'b0);
    exp_t e;
    e.nm = nm; e.q = eq; e.w = ew; e.neq = neq;
    sb.push_back(e);
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; oe = 1'b1; d = '0; sel = '0; lane = 1'b0;
    we = 1'b0; en = 1'b0; op = 2'b00;
    chk("reset", 16'h0000, 1'b0);
    rst = 1'b1;

    // byte loads and tri-state
    cyc(2'd0, 1'b0, 8'h64, 1, 0, 2'b00);
    cyc(2'd0, 1'b1, 8'h40, 1, 0, 2'b00);
    chk("load", 16'h4064, 1'b0);
    oe = 1'b0;
    chk("oe_off", 16'h4064, 1'b0, 1'b1);
    oe = 1'b1;

    // register independence
    cyc(2'd2, 1'b0, 8'h34, 1, 0, 2'b00);
    cyc(2'd2, 1'b1, 8'h12, 1, 0, 2'b00);
    chk("sel2", 16'h1234, 1'b0);
    cyc(2'd0, 1'b0, 8'h00, 0, 0, 2'b00);
    chk("sel0", 16'h4064, 1'b0);
    cyc(2'd1, 1'b0, 8'h00, 0, 0, 2'b00);
    chk("sel1", 16'h0000, 1'b0);

    // wrap on increment and decrement
    cyc(2'd1, 1'b0, 8'hFF, 1, 0, 2'b00);
    cyc(2'd1, 1'b1, 8'hFF, 1, 0, 2'b00);
    chk("ffff", 16'hFFFF, 1'b0);
    cyc(2'd1, 1'b0, 8'h00, 0, 1, 2'b01);
    chk("inc_wrap", 16'h0000, 1'b1);
    cyc(2'd1, 1'b0, 8'h00, 0, 0, 2'b00);
    chk("wrap_pulse", 16'h0000, 1'b0);
    cyc(2'd1, 1'b0, 8'h00, 0, 1, 2'b10);
    chk("dec_wrap", 16'hFFFF, 1'b1);
    cyc(2'd1, 1'b0, 8'h00, 0, 1, 2'b00);
    chk("op_hold", 16'hFFFF, 1'b0);

    // signed offsets
    cyc(2'd0, 1'b0, 8'hF0, 0, 1, 2'b11);
    chk("add_neg", 16'h4054, 1'b0);
    cyc(2'd3, 1'b0, 8'h05, 1, 0, 2'b00);
    cyc(2'd3, 1'b0, 8'hF0, 0, 1, 2'b11);
    chk("add_under", 16'hFFF5, 1'b1);
    cyc(2'd2, 1'b0, 8'h7F, 0, 1, 2'b11);
    chk("add_pos", 16'h12B3, 1'b0);
    cyc(2'd1, 1'b0, 8'h01, 0, 1, 2'b11);
    chk("add_over", 16'h0000, 1'b1);

    // write beats modify
    cyc(2'd0, 1'b0, 8'hFF, 1, 0, 2'b00);
    cyc(2'd0, 1'b1, 8'h00, 1, 0, 2'b00);
    chk("pre_prio", 16'h00FF, 1'b0);
    cyc(2'd0, 1'b0, 8'h10, 1, 1, 2'b01);
    chk("priority", 16'h0010, 1'b0);
    cyc(2'd0, 1'b0, 8'h00, 0, 1, 2'b10);
    chk("dec_plain", 16'h000F, 1'b0);

    // async reset between edges while wrap is high
    cyc(2'd1, 1'b0, 8'h00, 0, 1, 2'b10);
    cyc(2'd1, 1'b0, 8'h00, 0, 1, 2'b01);
    #1 rst = 1'b0;
    chk("async_rst", 16'h0000, 1'b0);
    cyc(2'd0, 1'b0, 8'hAA, 1, 1, 2'b01);
    chk("rst_hold", 16'h0000, 1'b0);
    rst = 1'b1;
    cyc(2'd2, 1'b0, 8'h00, 0, 0, 2'b00);
    chk("rst_clr2", 16'h0000, 1'b0);
    cyc(2'd0, 1'b0, 8'h01, 1, 0, 2'b00);
    chk("post_rst", 16'h0001, 1'b0);

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acu_bank.md
ACU_BANK -- requirements
Module: acu_bank

Interface
REQ-001 Parameter DW, default 8: data bus width in bits.
REQ-002 Parameter AW, default 16: address register width in bits; SHALL be an integer multiple of DW, AW/DW >= 1.
REQ-003 Parameter NREG, default 4: number of address registers, >= 1.
REQ-004 Derived widths: SW = max(1, clog2(NREG)); LW = max(1, clog2(AW/DW)).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 d  in  DW  byte-lane load data, or signed offset for add.
REQ-008 sel  in  SW  selects the address register for write, modify and output.
REQ-009 lane  in  LW  byte lane for writes; lane k covers bits [k*DW +: DW].
REQ-010 we  in  1  write enable for the selected lane.
REQ-011 en  in  1  modify enable.
REQ-012 op  in  2  modify op: 00 hold, 01 increment, 10 decrement, 11 add sign-extended d.
REQ-013 oe  in  1  output enable.
REQ-014 q  out  AW  selected register value when oe=1, high-impedance otherwise.
REQ-015 wrap  out  1  registered wrap flag.

Function
REQ-016 Storage: NREG independent AW-bit registers; only reg[sel] is affected in any cycle.
REQ-017 Write: at a rising edge with we=1, reg[sel][lane*DW +: DW] <= d; other lanes and other registers unchanged.
REQ-018 Modify: at a rising edge with we=0 and en=1, reg[sel] <= reg[sel] +1 (op 01), -1 (op 10), or + sign_extend(d, AW) (op 11); op 00 leaves it unchanged.
REQ-019 Arithmetic: modulo 2^AW; no saturation.
REQ-020 Priority: we=1 and en=1 in the same cycle -> write only; modify suppressed; wrap <= 0.
REQ-021 Wrap: at every rising edge, wrap <= 1 iff a modify executed whose unsigned result left [0, 2^AW-1]: inc from all-ones, dec from zero, add over- or underflow; otherwise wrap <= 0. wrap is therefore a one-cycle pulse.
REQ-022 Output: q is combinational from the current sel and oe. Latency is zero from sel/oe; a write or modify is visible on q after the same rising edge.
REQ-023 Out-of-range sel (sel >= NREG, NREG not a power of 2): writes and modifies are ignored, wrap <= 0, and q = 0 when oe=1.
REQ-024 lane >= AW/DW: the write is ignored.
REQ-025 Illegal parameters (AW mod DW != 0) SHALL cause an elaboration error.

Reset
REQ-026 rst=0 SHALL immediately, independent of clk, clear all registers to 0 and wrap to 0; q reads 0 if oe=1.
REQ-027 While rst=0, we and en are ignored; the first update occurs at the first rising edge after rst returns to 1.
REQ-028 Reset mid-operation (asserted between edges after a load): the partial contents are discarded; no state is retained.

Verification (defaults DW=8, AW=16, NREG=4)
REQ-029 Byte load: sel=0, lane0 d=0x64 we=1, then lane1 d=0x40 we=1, oe=1 -> q=0x4064; oe=0 -> q=Z.
REQ-030 Independence: load reg2=0x1234; sel=0 -> q=0x4064; sel=2 -> q=0x1234; sel=1 -> q=0x0000.
REQ-031 Wrap: reg1=0xFFFF, en=1 op=01 -> q=0x0000, wrap=1 for exactly one cycle; then op=10 -> q=0xFFFF, wrap=1.
REQ-032 Offset: reg0=0x4064, d=0xF0 op=11 -> 0x4054, wrap=0; reg3=0x0005, d=0xF0 op=11 -> 0xFFF5, wrap=1.
REQ-033 Priority: reg0=0x00FF, we=1 lane0 d=0x10 with en=1 op=01 -> q=0x0010, wrap=0.
REQ-034 Async reset: registers loaded, oe=1, rst=0 between edges -> q=0x0000 and wrap=0 before the next edge; release, load lane0 d=0x01 -> q=0x0001.
